// File: rtl/load_store_unit_if.sv
// Ready-handshaked data-memory port between the load/store unit (master) and memory (slave).
interface load_store_unit_if;
  logic        mem_req_out;
  logic        mem_we_out;
  logic [31:0] mem_addr_out;
  logic [31:0] mem_wdata_out;
  logic [3:0]  mem_wstrb_out;
  logic        mem_ready_in;
  logic [31:0] mem_rdata_in;

  modport master (
    output mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out, mem_wstrb_out,
    input  mem_ready_in, mem_rdata_in
  );

  modport slave (
    input  mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out, mem_wstrb_out,
    output mem_ready_in, mem_rdata_in
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store stage: turns the ALU address into one memory access, stalls the
// core until it retires, and extends load data.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               valid_in,
  input  logic [6:0]         opcode_in,
  input  logic [2:0]         funct3_in,
  input  logic [31:0]        alu_result_in,
  input  logic [31:0]        rs2_value_in,
  output logic               stall_out,
  output logic               done_out,
  output logic               load_valid_out,
  output logic [31:0]        load_data_out,
  output logic               error_out,
  load_store_unit_if.master  mem
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, next_state;
  logic             is_load, is_store, accept, f3_legal, aligned, access_ok;
  logic [3:0]       st_strb;
  logic [31:0]      st_data;
  logic [31:0]      rd_shift, rd_ext;
  logic             timed_out;

  logic             req_we;
  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;
  logic [3:0]       req_wstrb;
  logic             req_is_load;
  logic [2:0]       req_funct3;
  logic [1:0]       req_offset;
  logic             err_flag;
  logic             load_ok;
  logic [CNT_W-1:0] req_cnt;
  logic [31:0]      load_data_q;

  // Decode of the presented instruction: legality, alignment and store lane shaping.
  always_comb begin
    is_load  = (opcode_in == OP_LOAD);
    is_store = (opcode_in == OP_STORE);
    accept   = valid_in && (is_load || is_store);
    if (is_load)
      f3_legal = (funct3_in != 3'b011) && (funct3_in[2:1] != 2'b11);
    else
      f3_legal = (funct3_in[2] == 1'b0) && (funct3_in[1:0] != 2'b11);
    case (funct3_in[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~alu_result_in[0];
      2'b10:   aligned = (alu_result_in[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
    access_ok = f3_legal && aligned;
    case (funct3_in[1:0])
      2'b00: begin
        st_strb = 4'b0001 << alu_result_in[1:0];
        st_data = {4{rs2_value_in[7:0]}};
      end
      2'b01: begin
        st_strb = alu_result_in[1] ? 4'b1100 : 4'b0011;
        st_data = {2{rs2_value_in[15:0]}};
      end
      default: begin
        st_strb = 4'b1111;
        st_data = rs2_value_in;
      end
    endcase
  end

  always_comb begin
    rd_shift = mem.mem_rdata_in >> {req_offset, 3'b000};
    case (req_funct3)
      3'b000:  rd_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  rd_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  rd_ext = {24'h000000, rd_shift[7:0]};
      3'b101:  rd_ext = {16'h0000, rd_shift[15:0]};
      default: rd_ext = rd_shift;
    endcase
  end

  assign timed_out = TIMEOUT_EN && (state == BUSY) && !mem.mem_ready_in && (req_cnt == CNT_LAST);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)
      state <= IDLE;
    else
      state <= next_state;
  end

  // Stall is gated by reset so a held instruction cannot stall the core during reset.
  always_comb begin
    next_state = state;
    stall_out  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stall_out  = rst_n_in;
          next_state = access_ok ? BUSY : DONE;
        end
      end
      BUSY: begin
        stall_out = 1'b1;
        if (mem.mem_ready_in || timed_out)
          next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      req_we      <= 1'b0;
      req_addr    <= '0;
      req_wdata   <= '0;
      req_wstrb   <= '0;
      req_is_load <= 1'b0;
      req_funct3  <= '0;
      req_offset  <= '0;
      err_flag    <= 1'b0;
      load_ok     <= 1'b0;
      req_cnt     <= '0;
      load_data_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            err_flag <= !access_ok;
            load_ok  <= 1'b0;
            req_cnt  <= '0;
            if (access_ok) begin
              req_we      <= is_store;
              req_addr    <= {alu_result_in[31:2], 2'b00};
              req_wdata   <= is_store ? st_data : 32'h0;
              req_wstrb   <= is_store ? st_strb : 4'b0000;
              req_is_load <= is_load;
              req_funct3  <= funct3_in;
              req_offset  <= alu_result_in[1:0];
            end
          end
        end
        BUSY: begin
          if (mem.mem_ready_in) begin
            if (req_is_load) begin
              load_data_q <= rd_ext;
              load_ok     <= 1'b1;
            end
            req_we    <= 1'b0;
            req_wstrb <= 4'b0000;
          end else if (timed_out) begin
            err_flag  <= 1'b1;
            req_we    <= 1'b0;
            req_wstrb <= 4'b0000;
          end else begin
            req_cnt <= req_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          err_flag <= 1'b0;
          load_ok  <= 1'b0;
        end
        default: begin
          err_flag <= 1'b0;
          load_ok  <= 1'b0;
        end
      endcase
    end
  end

  assign mem.mem_req_out   = (state == BUSY);
  assign mem.mem_we_out    = req_we;
  assign mem.mem_addr_out  = req_addr;
  assign mem.mem_wdata_out = req_wdata;
  assign mem.mem_wstrb_out = req_wstrb;

  assign done_out       = (state == DONE);
  assign error_out      = (state == DONE) && err_flag;
  assign load_valid_out = (state == DONE) && load_ok;
  assign load_data_out  = load_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expectations are queued when an instruction is
// driven and compared when the DUT retires it.
module tb_load_store_unit;
  localparam int TO = 4;
  localparam int MAX_WAIT = 12;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;

  typedef struct {
    logic        err;
    logic        lv;
    logic [31:0] load_data;
    int          done_cyc;
    int          req_cycles;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        is_store;
  } exp_t;

  logic        clk_in;
  logic        rst_n_in;
  logic        valid_in;
  logic [6:0]  opcode_in;
  logic [2:0]  funct3_in;
  logic [31:0] alu_result_in;
  logic [31:0] rs2_value_in;
  logic        stall_out;
  logic        done_out;
  logic        load_valid_out;
  logic [31:0] load_data_out;
  logic        error_out;

  load_store_unit_if mem_bus ();

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .valid_in       (valid_in),
    .opcode_in      (opcode_in),
    .funct3_in      (funct3_in),
    .alu_result_in  (alu_result_in),
    .rs2_value_in   (rs2_value_in),
    .stall_out      (stall_out),
    .done_out       (done_out),
    .load_valid_out (load_valid_out),
    .load_data_out  (load_data_out),
    .error_out      (error_out),
    .mem            (mem_bus)
  );

  int          check_count = 0;
  int          fail_count  = 0;
  exp_t        sb_q[$];
  logic [31:0] last_load = 32'h0;

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] rs2, input logic [31:0] rdata, input int ready_at,
                                 input logic [31:0] prev_load);
    exp_t        e;
    logic [7:0]  b;
    logic [15:0] h;
    bit          ld, legal, aligned;
    ld = (op == LD);
    e.err = 1'b0; e.lv = 1'b0; e.load_data = prev_load; e.done_cyc = 1; e.req_cycles = 0;
    e.we = 1'b0; e.addr = 32'h0; e.wdata = 32'h0; e.strb = 4'h0; e.is_store = !ld;
    legal = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
    if (f3[1:0] == 2'b01)      aligned = (addr[0] == 1'b0);
    else if (f3[1:0] == 2'b10) aligned = (addr[1:0] == 2'b00);
    else                       aligned = 1'b1;
    if (!(legal && aligned)) begin
      e.err = 1'b1;
      return e;
    end
    e.addr = {addr[31:2], 2'b00};
    e.we   = !ld;
    if (!ld) begin
      case (f3)
        3'd0: begin
          case (addr[1:0])
            2'd0: e.strb = 4'b0001;
            2'd1: e.strb = 4'b0010;
            2'd2: e.strb = 4'b0100;
            default: e.strb = 4'b1000;
          endcase
          e.wdata = {rs2[7:0], rs2[7:0], rs2[7:0], rs2[7:0]};
        end
        3'd1: begin
          e.strb  = addr[1] ? 4'b1100 : 4'b0011;
          e.wdata = {rs2[15:0], rs2[15:0]};
        end
        default: begin
          e.strb  = 4'b1111;
          e.wdata = rs2;
        end
      endcase
    end
    if (ready_at >= 1 && ready_at <= TO) begin
      e.req_cycles = ready_at;
      e.done_cyc   = ready_at + 1;
      if (ld) begin
        b = rdata[8*int'(addr[1:0]) +: 8];
        h = addr[1] ? rdata[31:16] : rdata[15:0];
        e.lv = 1'b1;
        case (f3)
          3'd0: e.load_data = {{24{b[7]}}, b};
          3'd1: e.load_data = {{16{h[15]}}, h};
          3'd4: e.load_data = {24'h0, b};
          3'd5: e.load_data = {16'h0, h};
          default: e.load_data = rdata;
        endcase
      end
    end else begin
      e.err        = 1'b1;
      e.req_cycles = TO;
      e.done_cyc   = TO + 1;
    end
    return e;
  endfunction

  // Presents one instruction in cycle T, plays the memory side, and scores the retire cycle.
  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] rs2, input logic [31:0] rdata, input int ready_at);
    exp_t e, got;
    int   req_seen;
    int   done_at;
    e = model(op, f3, addr, rs2, rdata, ready_at, last_load);
    if (e.lv) last_load = e.load_data;
    sb_q.push_back(e);
    @(posedge clk_in); #1;
    valid_in = 1'b1; opcode_in = op; funct3_in = f3; alu_result_in = addr; rs2_value_in = rs2;
    mem_bus.mem_ready_in = 1'b0; mem_bus.mem_rdata_in = rdata;
    @(negedge clk_in);
    checkOutput("stall_accept", 32'(stall_out), 32'd1);
    checkOutput("req_at_accept", 32'(mem_bus.mem_req_out), 32'd0);
    req_seen = 0;
    done_at  = 0;
    for (int cyc = 1; cyc <= MAX_WAIT && done_at == 0; cyc++) begin
      @(posedge clk_in); #1;
      if (done_out) begin
        done_at = cyc;
        valid_in = 1'b0;
        mem_bus.mem_ready_in = 1'b0;
      end else if (mem_bus.mem_req_out) begin
        req_seen++;
        mem_bus.mem_ready_in = (req_seen == ready_at);
      end else begin
        mem_bus.mem_ready_in = 1'b0;
      end
      @(negedge clk_in);
      if (done_at != 0) begin
        if (sb_q.size() == 0) begin
          checkOutput("sb_underflow", 32'd1, 32'd0);
        end else begin
          got = sb_q.pop_front();
          checkOutput("done_cycle", 32'(done_at), 32'(got.done_cyc));
          checkOutput("req_cycles", 32'(req_seen), 32'(got.req_cycles));
          checkOutput("error_out", 32'(error_out), 32'(got.err));
          checkOutput("load_valid", 32'(load_valid_out), 32'(got.lv));
          checkOutput("load_data", load_data_out, got.load_data);
          checkOutput("stall_done", 32'(stall_out), 32'd0);
        end
      end else begin
        checkOutput("stall_busy", 32'(stall_out), 32'd1);
        if (mem_bus.mem_req_out) begin
          checkOutput("mem_addr", mem_bus.mem_addr_out, e.addr);
          checkOutput("mem_we", 32'(mem_bus.mem_we_out), 32'(e.we));
          checkOutput("mem_wstrb", 32'(mem_bus.mem_wstrb_out), 32'(e.strb));
          if (e.is_store) checkOutput("mem_wdata", mem_bus.mem_wdata_out, e.wdata);
        end
      end
    end
    if (done_at == 0) begin
      checkOutput("done_missing", 32'd0, 32'd1);
      valid_in = 1'b0;
      mem_bus.mem_ready_in = 1'b0;
      if (sb_q.size() != 0) got = sb_q.pop_front();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n_in = 1'b0; valid_in = 1'b1; opcode_in = LD; funct3_in = 3'd2;
    alu_result_in = 32'h100; rs2_value_in = 32'h0;
    mem_bus.mem_ready_in = 1'b0; mem_bus.mem_rdata_in = 32'h0;
    repeat (2) @(negedge clk_in);
    checkOutput("rst_stall", 32'(stall_out), 32'd0);
    checkOutput("rst_req", 32'(mem_bus.mem_req_out), 32'd0);
    checkOutput("rst_done", 32'(done_out), 32'd0);
    checkOutput("rst_load_data", load_data_out, 32'h0);
    valid_in = 1'b0;
    rst_n_in = 1'b1;

    $display("[TB] directed accesses");
    applyStimulus(ST, 3'd2, 32'h0000_1000, 32'hDEADBEEF, 32'h0, 1);
    applyStimulus(LD, 3'd0, 32'h0000_2003, 32'h0, 32'h80FF1234, 3);
    checkOutput("lb_value", load_data_out, 32'hFFFFFF80);
    applyStimulus(LD, 3'd4, 32'h0000_2003, 32'h0, 32'h80FF1234, 3);
    checkOutput("lbu_value", load_data_out, 32'h00000080);
    applyStimulus(ST, 3'd1, 32'h0000_0006, 32'h0000ABCD, 32'h0, 2);
    applyStimulus(LD, 3'd1, 32'h0000_0005, 32'h0, 32'h12345678, 1);
    applyStimulus(LD, 3'd3, 32'h0000_0000, 32'h0, 32'h12345678, 1);
    checkOutput("illegal_keeps_data", load_data_out, 32'h00000080);
    applyStimulus(LD, 3'd2, 32'h0000_0010, 32'h0, 32'h11223344, 0);
    applyStimulus(LD, 3'd2, 32'h0000_0010, 32'h0, 32'h11223344, 4);
    checkOutput("lw_last_cycle", load_data_out, 32'h11223344);
    applyStimulus(ST, 3'd0, 32'h0000_0301, 32'h000000A5, 32'h0, 1);
    applyStimulus(LD, 3'd5, 32'h0000_0042, 32'h0, 32'h80017FFF, 2);
    checkOutput("lhu_value", load_data_out, 32'h00008001);
    applyStimulus(LD, 3'd1, 32'h0000_0042, 32'h0, 32'h80017FFF, 1);
    checkOutput("lh_value", load_data_out, 32'hFFFF8001);
    applyStimulus(ST, 3'd2, 32'h0000_0002, 32'h1, 32'h0, 1);
    applyStimulus(ST, 3'd3, 32'h0000_0000, 32'h1, 32'h0, 1);

    $display("[TB] non-memory opcode");
    @(posedge clk_in); #1;
    valid_in = 1'b1; opcode_in = 7'b0110011; funct3_in = 3'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      checkOutput("alu_op_stall", 32'(stall_out), 32'd0);
      checkOutput("alu_op_done", 32'(done_out), 32'd0);
    end
    valid_in = 1'b0;

    $display("[TB] random accesses");
    for (int i = 0; i < 24; i++) begin
      applyStimulus(($urandom_range(0, 1) == 1) ? LD : ST, 3'($urandom_range(0, 7)),
                    $urandom, $urandom, $urandom, int'($urandom_range(0, 4)));
    end

    $display("[TB] reset during busy");
    @(posedge clk_in); #1;
    valid_in = 1'b1; opcode_in = ST; funct3_in = 3'd2; alu_result_in = 32'h40; rs2_value_in = 32'h12345678;
    mem_bus.mem_ready_in = 1'b0;
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    checkOutput("pre_rst_req", 32'(mem_bus.mem_req_out), 32'd1);
    rst_n_in = 1'b0;
    #1;
    checkOutput("arst_req", 32'(mem_bus.mem_req_out), 32'd0);
    checkOutput("arst_we", 32'(mem_bus.mem_we_out), 32'd0);
    checkOutput("arst_addr", mem_bus.mem_addr_out, 32'h0);
    checkOutput("arst_wdata", mem_bus.mem_wdata_out, 32'h0);
    checkOutput("arst_wstrb", 32'(mem_bus.mem_wstrb_out), 32'd0);
    checkOutput("arst_stall", 32'(stall_out), 32'd0);
    checkOutput("arst_load_data", load_data_out, 32'h0);
    last_load = 32'h0;
    valid_in = 1'b0;
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(posedge clk_in); #1;
    mem_bus.mem_ready_in = 1'b1;
    @(negedge clk_in);
    checkOutput("late_ready_req", 32'(mem_bus.mem_req_out), 32'd0);
    @(posedge clk_in); #1;
    mem_bus.mem_ready_in = 1'b0;
    @(negedge clk_in);
    checkOutput("late_ready_done", 32'(done_out), 32'd0);
    applyStimulus(LD, 3'd2, 32'h0000_0080, 32'h0, 32'hCAFEF00D, 2);
    checkOutput("lw_after_rst", load_data_out, 32'hCAFEF00D);

    checkOutput("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle data-memory access stage directly downstream of the ALU in the RISC-V core. Takes the ALU result as the effective address for RV32I loads (LB/LH/LW/LBU/LHU) and stores (SB/SH/SW) and drives a ready-handshaked data-memory port. Builds byte-lane strobes and replicated store data, and sign- or zero-extends load data. Stalls the core until the access finishes.

## Interface
- TIMEOUT_CYCLES, 256: maximum number of request cycles to wait for mem_ready_in; 0 disables the timeout.
- clk_in  input  1  clock; everything is rising-edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- valid_in  input  1  instruction present this cycle; held by the core while stall_out is 1.
- opcode_in  input  7  instruction opcode; LOAD = 7'b0000011, STORE = 7'b0100011; any other opcode is ignored.
- funct3_in  input  3  access width and signedness.
- alu_result_in  input  32  effective address (rs1 + imm) from the ALU.
- rs2_value_in  input  32  store data.
- stall_out  output  1  combinational; core must hold PC and instruction.
- done_out  output  1  one-cycle pulse when any memory instruction completes, including error completions.
- load_valid_out  output  1  one-cycle pulse; load_data_out is valid for a successful load.
- load_data_out  output  32  extended load result; holds its value until the next successful load.
- error_out  output  1  one-cycle pulse with done_out on misalign, illegal funct3 or timeout.
- mem_req_out  output  1  memory request.
- mem_we_out  output  1  1 = write.
- mem_addr_out  output  32  word address, with {alu_result_in[31:2], 2'b00}.
- mem_wdata_out  output  32  write data.
- mem_wstrb_out  output  4  byte write enables; 0 for reads.
- mem_ready_in  input  1  memory accepts or completes the access this cycle.
- mem_rdata_in  input  32  read word; valid when mem_ready_in is 1 on a read.

## Operation
- The FSM has three states: IDLE, BUSY and DONE.
- IDLE:
  - An instruction is accepted when valid_in is 1 and the opcode is LOAD or STORE.
  - A legal, aligned access latches all memory outputs and moves to BUSY.
  - A misaligned access or an illegal funct3 moves to DONE with the error flag set and makes no memory access.
- Alignment rules: a halfword needs addr[0] = 0; a word needs addr[1:0] = 0.
- Illegal funct3 values: for loads 011, 110 and 111; for stores, anything 011 or above.
- BUSY:
  - mem_req_out = 1 for the whole state.
  - All memory outputs stay stable while mem_req_out is 1.
  - When mem_ready_in = 1, the access completes and the FSM moves to DONE. A load captures the extended rdata at that point.
- Timeout: a counter counts request cycles. If mem_ready_in is still 0 on cycle number TIMEOUT_CYCLES, the access is abandoned and the FSM moves to DONE with the error flag set. If ready arrives on that final cycle, the access completes normally.
- DONE lasts exactly one cycle and then returns to IDLE.
  - done_out = 1. load_valid_out = 1 for a successful load. error_out = 1 if the error flag is set.
  - valid_in is ignored in DONE; this is the retire cycle.
- Stores:
  - SB: strobe = 1 << addr[1:0]; wdata = {4{rs2[7:0]}}.
  - SH: strobe = addr[1] ? 1100 : 0011; wdata = {2{rs2[15:0]}}.
  - SW: strobe = 1111; wdata = rs2.
- Loads select a byte or halfword from rdata at offset 8·addr[1:0]:
  - LB and LH sign-extend.
  - LBU and LHU zero-extend.
  - LW passes the word through.
- stall_out = (IDLE and the instruction is accepted) or BUSY. It is 0 in DONE.
- mem_ready_in is ignored whenever mem_req_out is 0.

## Timing
- Reset (async, any state) forces IDLE and sets every registered output to 0: mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out, mem_wstrb_out, done_out, load_valid_out, error_out and load_data_out.
  - stall_out is 0 while reset is held.
  - An in-flight request is dropped, and a late mem_ready_in has no effect.
- Legal access accepted in cycle T:
  - stall_out = 1 in T.
  - mem_req_out = 1 from T+1.
  - If ready is first high in T+k (k ≥ 1), DONE is in T+k+1 with stall_out = 0, and IDLE is in T+k+2.
- Minimum occupancy is 3 cycles (T, T+1, T+2).
- Error at acceptance in T: stall_out = 1 in T, DONE in T+1, and mem_req_out stays 0.
- A back-to-back memory instruction presented in the cycle after DONE is accepted normally.

## Test plan
- SW of addr 0x1000 with rs2 0xDEADBEEF, ready in the first request cycle: one request cycle with addr 0x1000, strobe 1111, wdata 0xDEADBEEF, we 1; done_out in T+2; stall high in T and T+1 only.
- LB of addr 0x2003 with rdata 0x80FF1234 and ready after 3 request cycles: load_data_out = 0xFFFFFF80 and load_valid_out pulses once. LBU of the same access gives 0x00000080.
- SH of addr 0x0006 with rs2 0x0000ABCD: strobe 1100, wdata 0xABCDABCD. LH of addr 0x0005: error_out and done_out in T+1, no mem_req_out.
- Load funct3 = 011: error_out in T+1, and load_data_out keeps its previous value.
- TIMEOUT_CYCLES = 4 with ready held low: mem_req_out high for exactly 4 cycles, then done_out and error_out. A repeat run with ready high on the 4th request cycle completes without error.
- rst_n_in low mid-BUSY: outputs return to 0 immediately. A late ready gives no done_out, and the next LW completes normally.
